// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared widths and state encoding for the truth-table capture and classification stages
package tt_pkg;

  localparam int N_IN     = 7;
  localparam int TT_W     = 128;
  localparam int ONES_W   = 8;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - loadable down-counter; tick marks the last cycle of each SETTLE window
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt;

  // tick is combinational so the sampling edge is the one that closes the window
  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - exhaustive 7-input truth-table sweep with popcount and golden compare
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int              SETTLE    = 1,
  parameter logic [TT_W-1:0] GOLDEN_TT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic [N_IN-1:0]   x,
  input  logic              f_in,
  output logic [TT_W-1:0]   tt,
  output logic [ONES_W-1:0] ones,
  output logic              match,
  output logic              tt_valid,
  input  logic              tt_ready
);

  localparam logic [N_IN-1:0] LAST_X = N_IN'(TT_W - 1);

  state_t          state;
  logic            tick;
  logic            timer_load;
  logic            timer_en;
  logic [TT_W-1:0] tt_next;

  assign timer_load = (state == IDLE) && start;
  assign timer_en   = (state == SWEEP) && !abort;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .tick (tick)
  );

  // x doubles as the sweep index; the final table feeds the match compare in the same edge
  always_comb begin
    tt_next    = tt;
    tt_next[x] = f_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      busy     <= 1'b0;
      tt       <= '0;
      ones     <= '0;
      match    <= 1'b0;
      tt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SWEEP;
            x     <= '0;
            busy  <= 1'b1;
            tt    <= '0;
            ones  <= '0;
            match <= 1'b0;
          end
        end
        SWEEP: begin
          if (abort) begin
            state <= IDLE;
            x     <= '0;
            busy  <= 1'b0;
            tt    <= '0;
            ones  <= '0;
          end else if (tick) begin
            tt   <= tt_next;
            ones <= ones + ONES_W'(f_in);
            if (x == LAST_X) begin
              state    <= DONE;
              x        <= '0;
              busy     <= 1'b0;
              tt_valid <= 1'b1;
              match    <= (tt_next == GOLDEN_TT);
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DONE: begin
          if (tt_ready) begin
            tt_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - scoreboard bench for tt_sweep_capture with a behavioural FUT and table model
module tb_tt_sweep_capture;
  import tt_pkg::*;

  localparam int           SET  = 3;
  localparam logic [127:0] GOLD = {16{8'hE8}};

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic         busy;
  logic [6:0]   x;
  logic         f_in;
  logic [127:0] tt;
  logic [7:0]   ones;
  logic         match;
  logic         tt_valid;
  logic         tt_ready;

  tt_sweep_capture #(
    .SETTLE    (SET),
    .GOLDEN_TT (GOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .x        (x),
    .f_in     (f_in),
    .tt       (tt),
    .ones     (ones),
    .match    (match),
    .tt_valid (tt_valid),
    .tt_ready (tt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] tt;
    logic [7:0]   ones;
    logic         match;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           mode  = 0;
  logic [127:0] rnd_tab = '0;

  // modes: 0 maj(x0,x1,x2), 1 constant one, 2 x6, 3 random table
  function automatic logic fut_ref(int m, int i, logic [127:0] tab);
    case (m)
      0:       return (((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) >= 2);
      1:       return 1'b1;
      2:       return (i >= 64);
      default: return tab[i];
    endcase
  endfunction

  assign f_in = fut_ref(mode, int'(x), rnd_tab);

  function automatic exp_t model(int m, logic [127:0] tab);
    exp_t e;
    int   cnt;
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      e.tt[i] = fut_ref(m, i, tab);
      cnt += int'(e.tt[i]);
    end
    e.ones  = 8'(cnt);
    e.match = (e.tt == GOLD);
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: x stepping while busy, and the scoreboard pop on every handshake
  int sc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && busy) begin
      chk("x_step", 128'(x), 128'(sc / SET));
      sc++;
    end else begin
      sc = 0;
    end
    if (!rst && tt_valid && tt_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 128'(tt_valid), 128'(0));
      end else begin
        e = sbq.pop_front();
        chk("sb_tt", tt, e.tt);
        chk("sb_ones", 128'(ones), 128'(e.ones));
        chk("sb_match", 128'(match), 128'(e.match));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_x"}, 128'(x), 128'(0));
    chk({tag, "_tt"}, tt, 128'(0));
    chk({tag, "_ones"}, 128'(ones), 128'(0));
    chk({tag, "_match"}, 128'(match), 128'(0));
    chk({tag, "_valid"}, 128'(tt_valid), 128'(0));
  endtask

  task automatic issue_start(input int m, input logic with_abort);
    mode = m;
    if (m == 3) rnd_tab = {$urandom, $urandom, $urandom, $urandom};
    sbq.push_back(model(m, rnd_tab));
    start = 1'b1;
    abort = with_abort;
    cyc();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      cyc();
    end
    if (busy) chk({tag, "_timeout"}, 128'(busy), 128'(0));
  endtask

  task automatic run_sweep(input string tag, input int m, input int rdy_delay, input logic check_len);
    int n;
    tt_ready = (rdy_delay == 0);
    issue_start(m, 1'b0);
    wait_done(tag, n);
    if (check_len) chk({tag, "_busy_len"}, 128'(n), 128'(128 * SET));
    chk({tag, "_valid_rise"}, 128'(tt_valid), 128'(1));
    if (rdy_delay > 0) begin
      repeat (rdy_delay) cyc();
      tt_ready = 1'b1;
    end
    cyc();
    chk({tag, "_valid_drop"}, 128'(tt_valid), 128'(0));
  endtask

  initial begin
    int   n;
    exp_t e;
    exp_t prev;

    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    tt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    cyc();
    chk_reset_vals("reset");

    // majority FUT matches the golden table
    run_sweep("maj", 0, 0, 1'b1);
    // constant one: full table, no golden match
    run_sweep("const1", 1, 0, 1'b1);

    // x6 FUT with a stalled consumer and ignored start pulses
    tt_ready = 1'b0;
    issue_start(2, 1'b0);
    wait_done("x6", n);
    e = model(2, rnd_tab);
    for (int i = 0; i < 20; i++) begin
      start = ($urandom_range(0, 1) == 1);
      cyc();
      start = 1'b0;
      if (i % 5 == 4) begin
        chk("x6_hold_valid", 128'(tt_valid), 128'(1));
        chk("x6_hold_tt", tt, e.tt);
        chk("x6_hold_busy", 128'(busy), 128'(0));
      end
    end
    tt_ready = 1'b1;
    start    = 1'b1;
    cyc();
    start = 1'b0;
    chk("x6_handshake_valid", 128'(tt_valid), 128'(0));
    cyc();
    chk("x6_start_ignored", 128'(busy), 128'(0));

    // abort mid-sweep discards the partial result
    issue_start(3, 1'b0);
    repeat (49) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    void'(sbq.pop_back());
    chk_reset_vals("abort");
    repeat (10) cyc();
    chk("abort_no_valid", 128'(tt_valid), 128'(0));

    // start with abort in IDLE: start wins
    issue_start(3, 1'b1);
    chk("start_abort_busy", 128'(busy), 128'(1));
    wait_done("start_abort", n);
    cyc();

    // async reset mid-sweep at x == 90
    issue_start(0, 1'b0);
    n = 0;
    while (x != 7'd90 && n < 1000) begin
      n++;
      cyc();
    end
    chk("rst_reach_x90", 128'(x), 128'(90));
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    void'(sbq.pop_back());
    #3;
    rst = 1'b0;
    cyc();
    run_sweep("post_rst", 0, 0, 1'b0);

    // back-to-back: start the cycle after returning to IDLE
    tt_ready = 1'b1;
    issue_start(3, 1'b0);
    prev = model(3, rnd_tab);
    wait_done("b2b", n);
    cyc();
    chk("b2b_idle_valid", 128'(tt_valid), 128'(0));
    chk("b2b_tt_held", tt, prev.tt);
    chk("b2b_ones_held", 128'(ones), 128'(prev.ones));
    issue_start(3, 1'b0);
    chk("b2b_busy", 128'(busy), 128'(1));
    chk("b2b_tt_cleared", tt, 128'(0));
    wait_done("b2b2", n);
    cyc();

    // randomized sweeps with random consumer stall
    for (int k = 0; k < 4; k++) run_sweep("rand", $urandom_range(0, 3), $urandom_range(0, 6), 1'b1);

    repeat (3) cyc();
    chk("sb_drained", 128'(sbq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
